// File: rtl/rt_port_input_buffer.sv
// RTPort ingress buffer: four-phase receiver, DEPTH-entry FIFO, four-phase sender.
// Define RT_IN_SYNC_EN to pass in_req/out_ack through 2-flop synchronizers.
module rt_port_input_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_req,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ack,
  output logic                     out_req,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    O_IDLE,
    O_REQ,
    O_REL
  } ostate_t;

  logic in_req_s;
  logic out_ack_s;

`ifdef RT_IN_SYNC_EN
  logic [1:0] req_sync;
  logic [1:0] ack_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[0], in_req};
      ack_sync <= {ack_sync[0], out_ack};
    end
  end

  assign in_req_s  = req_sync[1];
  assign out_ack_s = ack_sync[1];
`else
  assign in_req_s  = in_req;
  assign out_ack_s = out_ack;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  ostate_t          state;
  ostate_t          state_d;
  logic             wr_en;
  logic             load;
  logic             pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  // Full is judged on the current count; a same-cycle pop does not free a slot.
  assign wr_en = in_req_s & ~in_ack & ~full;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ack <= 1'b0;
    end else if (wr_en) begin
      in_ack <= 1'b1;
    end else if (!in_req_s) begin
      in_ack <= 1'b0;
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      O_IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = O_REQ;
        end
      end
      O_REQ: begin
        if (out_ack_s) begin
          pop     = 1'b1;
          state_d = O_REL;
        end
      end
      O_REL: begin
        if (!out_ack_s) state_d = O_IDLE;
      end
      default: state_d = O_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= O_IDLE;
      out_data <= '0;
    end else begin
      state <= state_d;
      if (load) out_data <= mem[rd_ptr];
    end
  end

  assign out_req = (state == O_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rt_port_input_buffer.sv
// Testbench for rt_port_input_buffer: handshake agents plus queue scoreboard.
// Honours RT_IN_SYNC_EN for the expected acknowledge latency.
module tb_rt_port_input_buffer;

`ifdef RT_IN_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_req;
  logic [31:0] in_data;
  logic        in_ack;
  logic        out_req;
  logic [31:0] out_data;
  logic        out_ack;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int fails  = 0;
  int max_cnt = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          rx_en   = 0;
  bit          rx_rand = 0;
  bit          tx_rand = 0;

  always #5 clk = ~clk;

  rt_port_input_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .count(count), .full(full), .empty(empty)
  );

  // One clock: invariant check, then the sender and core agents react.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) begin
      checks++;
      if (count > 3'd4 || full !== (count == 3'd4) || empty !== (count == 3'd0)) begin
        fails++;
        $display("FAIL flags: count=%0d full=%b empty=%b", count, full, empty);
      end
    end
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (out_req && !out_ack && rx_en && (!rx_rand || $urandom_range(0, 1) == 1)) begin
      rx_q.push_back(out_data);
      out_ack = 1'b1;
    end else if (!out_req && out_ack) begin
      out_ack = 1'b0;
    end
    if (!in_req && !in_ack && tx_q.size() != 0 && (!tx_rand || $urandom_range(0, 2) == 0)) begin
      in_data = tx_q.pop_front();
      in_req  = 1'b1;
    end else if (in_req && in_ack) begin
      in_req = 1'b0;
    end
  endtask

  task automatic wait_rx(input int k);
    int n = 0;
    while (rx_q.size() < k && n < 4000) begin
      step();
      n++;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    in_req  = 1'b0;
    in_data = '0;
    out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ack !== 1'b0 || out_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: in_ack=%b out_req=%b want 0 0", in_ack, out_req);
    end
    checks++;
    if (out_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_cnt: count=%0d empty=%b full=%b want 0 1 0", count, empty, full);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    int n = 0;
    rx_q.delete();
    rx_en = 0;
    tx_q.push_back(32'hA5A5_0001);
    step();
    do begin
      step();
      n++;
    end while (!in_ack && n < 20);
    checks++;
    if (n != 1 + SYNC) begin
      fails++;
      $display("FAIL single_lat: in_ack after %0d cycles want %0d", n, 1 + SYNC);
    end
    checks++;
    if (count !== 3'd1 || out_req !== 1'b0) begin
      fails++;
      $display("FAIL single_cnt1: count=%0d out_req=%b want 1 0", count, out_req);
    end
    step();
    checks++;
    if (out_req !== 1'b1 || out_data !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL single_out: out_req=%b data=%h want 1 a5a50001", out_req, out_data);
    end
    rx_en = 1;
    wait_rx(1);
    idle(8);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL single_rx: n=%0d want 1 flit a5a50001", rx_q.size());
    end
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || out_data !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL single_end: count=%0d empty=%b data=%h want 0 1 a5a50001",
               count, empty, out_data);
    end
  endtask

  task automatic test_fill();
    int n = 0;
    rx_q.delete();
    rx_en = 0;
    for (int i = 0; i < 5; i++) tx_q.push_back(32'h10 + i);
    while (!(in_req && in_data == 32'h14 && count == 3'd4) && n < 200) begin
      step();
      n++;
    end
    idle(6);
    checks++;
    if (full !== 1'b1 || count !== 3'd4) begin
      fails++;
      $display("FAIL fill_full: full=%b count=%0d want 1 4", full, count);
    end
    checks++;
    if (in_req !== 1'b1 || in_ack !== 1'b0) begin
      fails++;
      $display("FAIL fill_stall: in_req=%b in_ack=%b want 1 0", in_req, in_ack);
    end
    rx_en = 1;
    wait_rx(1);
    rx_en = 0;
    idle(12);
    checks++;
    if (count !== 3'd4 || in_req !== 1'b0 || tx_q.size() != 0) begin
      fails++;
      $display("FAIL fill_accept: count=%0d in_req=%b pending=%0d want 4 0 0",
               count, in_req, tx_q.size());
    end
    rx_en = 1;
    wait_rx(5);
    idle(8);
    checks++;
    if (rx_q.size() != 5) begin
      fails++;
      $display("FAIL fill_num: got %0d flits want 5", rx_q.size());
    end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 32'h10 + i) begin
        fails++;
        $display("FAIL fill_ord[%0d]: got %h want %h", i, rx_q[i], 32'h10 + i);
      end
    end
  endtask

  task automatic test_wrap();
    rx_q.delete();
    max_cnt = 0;
    rx_en   = 1;
    rx_rand = 0;
    for (int i = 0; i < 10; i++) tx_q.push_back(i);
    wait_rx(10);
    idle(8);
    checks++;
    if (rx_q.size() != 10) begin
      fails++;
      $display("FAIL wrap_num: got %0d flits want 10", rx_q.size());
    end
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 32'(i)) begin
        fails++;
        $display("FAIL wrap_ord[%0d]: got %h want %h", i, rx_q[i], i);
      end
    end
    checks++;
    if (max_cnt > 4 || count !== 3'd0) begin
      fails++;
      $display("FAIL wrap_cnt: max=%0d end=%0d want <=4 0", max_cnt, count);
    end
  endtask

  task automatic test_simul();
    int n = 0;
    rx_q.delete();
    rx_en = 0;
    tx_q.push_back(32'h20);
    tx_q.push_back(32'h21);
    while (!(count == 3'd2 && out_req && !in_req && !in_ack) && n < 200) begin
      step();
      n++;
    end
    in_data = 32'h22;
    in_req  = 1'b1;
    rx_q.push_back(out_data);
    out_ack = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!in_ack && n < 20);
    checks++;
    if (count !== 3'd2 || out_req !== 1'b0) begin
      fails++;
      $display("FAIL simul_cnt: count=%0d out_req=%b want 2 0", count, out_req);
    end
    rx_en = 1;
    wait_rx(3);
    idle(8);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== 32'h20 + i) begin
        fails++;
        $display("FAIL simul_ord[%0d]: got %h want %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 32'hx, 32'h20 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rx_q.delete();
    rx_en = 0;
    for (int i = 0; i < 3; i++) tx_q.push_back(32'h30 + i);
    while (!(count == 3'd3 && out_req) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (count !== 3'd3 || out_req !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre: count=%0d out_req=%b want 3 1", count, out_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ack !== 1'b0 || out_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL rmid_async: ack=%b req=%b count=%0d empty=%b want 0 0 0 1",
               in_ack, out_req, count, empty);
    end
    in_req  = 1'b0;
    out_ack = 1'b0;
    tx_q.delete();
    rx_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(2);
    rx_en = 1;
    tx_q.push_back(32'hBEEF);
    wait_rx(1);
    idle(8);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'hBEEF || count !== 3'd0) begin
      fails++;
      $display("FAIL rmid_after: n=%0d count=%0d want 1 flit beef count 0",
               rx_q.size(), count);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] v;
    rx_q.delete();
    rx_en   = 1;
    rx_rand = 1;
    tx_rand = 1;
    for (int i = 0; i < 40; i++) begin
      v = $urandom();
      exp_q.push_back(v);
      tx_q.push_back(v);
    end
    wait_rx(40);
    idle(10);
    checks++;
    if (rx_q.size() != 40) begin
      fails++;
      $display("FAIL rand_num: got %0d flits want 40", rx_q.size());
    end
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rand_ord[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
    rx_rand = 0;
    tx_rand = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simul();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
